// File: rtl/load_store_unit.sv
// Load/store unit between the core memory stage and a word-addressed 32-bit RAM.
// Sub-word stores use read-modify-write; loads are lane-extracted and sign/zero-extended.
module load_store_unit #(
    parameter int unsigned MEM_DEPTH = 256,
    parameter int unsigned WIDTH     = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_we,
    input  logic [2:0]       req_funct3,
    input  logic [WIDTH-1:0] req_addr,
    input  logic [WIDTH-1:0] req_wdata,
    output logic             resp_valid,
    output logic [WIDTH-1:0] resp_rdata,
    output logic             resp_err,
    output logic [WIDTH-1:0] mem_address,
    output logic [WIDTH-1:0] mem_data_in,
    input  logic [WIDTH-1:0] mem_data_out,
    output logic             mem_we
);

    localparam int unsigned IDX_W = WIDTH - 2;
    localparam logic [2:0]  F3_B  = 3'b000;
    localparam logic [2:0]  F3_H  = 3'b001;
    localparam logic [2:0]  F3_W  = 3'b010;
    localparam logic [2:0]  F3_BU = 3'b100;
    localparam logic [2:0]  F3_HU = 3'b101;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        MERGE = 3'd2,
        WRITE = 3'd3,
        RESP  = 3'd4
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [2:0]       f3_q;
    logic             we_q;
    logic [WIDTH-1:0] addr_q;
    logic [WIDTH-1:0] wdata_q;
    logic [WIDTH-1:0] merge_q;
    logic             req_err_c;
    logic             accept_c;
    logic [7:0]       byte_c;
    logic [15:0]      half_c;
    logic [WIDTH-1:0] load_ext_c;
    logic [WIDTH-1:0] merge_c;

    assign req_ready   = (state_q == IDLE);
    assign resp_valid  = (state_q == RESP);
    assign mem_we      = (state_q == WRITE);
    assign accept_c    = req_valid && req_ready;
    assign mem_address = {2'b00, addr_q[WIDTH-1:2]};
    assign mem_data_in = (f3_q == F3_W) ? wdata_q : merge_q;

    // Request legality: funct3 encoding, natural alignment and word index range
    always_comb begin
        req_err_c = 1'b0;
        if (req_we) begin
            case (req_funct3)
                F3_B:    req_err_c = 1'b0;
                F3_H:    req_err_c = req_addr[0];
                F3_W:    req_err_c = (req_addr[1:0] != 2'b00);
                default: req_err_c = 1'b1;
            endcase
        end else begin
            case (req_funct3)
                F3_B, F3_BU: req_err_c = 1'b0;
                F3_H, F3_HU: req_err_c = req_addr[0];
                F3_W:        req_err_c = (req_addr[1:0] != 2'b00);
                default:     req_err_c = 1'b1;
            endcase
        end
        if (req_addr[WIDTH-1:2] >= IDX_W'(MEM_DEPTH)) begin
            req_err_c = 1'b1;
        end
    end

    // Lane extraction for loads and lane replacement for sub-word stores
    always_comb begin
        byte_c  = mem_data_out[{addr_q[1:0], 3'b000} +: 8];
        half_c  = mem_data_out[{addr_q[1], 4'b0000} +: 16];
        merge_c = mem_data_out;
        case (f3_q)
            F3_B:    load_ext_c = {{24{byte_c[7]}}, byte_c};
            F3_BU:   load_ext_c = {24'h000000, byte_c};
            F3_H:    load_ext_c = {{16{half_c[15]}}, half_c};
            F3_HU:   load_ext_c = {16'h0000, half_c};
            default: load_ext_c = mem_data_out;
        endcase
        if (f3_q == F3_B) begin
            merge_c[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
        end else begin
            merge_c[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept_c) begin
                    if (req_err_c)               state_d = RESP;
                    else if (!req_we)            state_d = LOAD;
                    else if (req_funct3 == F3_W) state_d = WRITE;
                    else                         state_d = MERGE;
                end
            end
            LOAD:    state_d = RESP;
            MERGE:   state_d = WRITE;
            WRITE:   state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Request latches, merge word and response registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            f3_q       <= 3'b000;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            merge_q    <= '0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end else begin
            if (accept_c) begin
                f3_q     <= req_funct3;
                we_q     <= req_we;
                addr_q   <= req_addr;
                wdata_q  <= req_wdata;
                resp_err <= req_err_c;
            end
            if (state_q == LOAD && !we_q) begin
                resp_rdata <= load_ext_c;
            end
            if (state_q == MERGE) begin
                merge_q <= merge_c;
            end
            if (state_q == RESP) begin
                resp_rdata <= '0;
                resp_err   <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: behavioural word RAM, vector table, response scoreboard,
// plus reset-abort and back-to-back request sequences.
module tb_load_store_unit;

    localparam int unsigned DEPTH = 256;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] mem_address;
    logic [31:0] mem_data_in;
    logic [31:0] mem_data_out;
    logic        mem_we;

    logic [31:0] ram [0:DEPTH-1];

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          wr;
    } vec_t;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    vec_t vecs[$];
    vec_t b2b[$];
    exp_t sb_q[$];

    int n_checks = 0;
    int n_fail   = 0;
    int we_cnt   = 0;
    int n_resp   = 0;
    int n_sent   = 0;

    load_store_unit #(.MEM_DEPTH(DEPTH), .WIDTH(32)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_funct3   (req_funct3),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_rdata   (resp_rdata),
        .resp_err     (resp_err),
        .mem_address  (mem_address),
        .mem_data_in  (mem_data_in),
        .mem_data_out (mem_data_out),
        .mem_we       (mem_we)
    );

    always #5 clk = ~clk;

    always_comb begin
        mem_data_out = (mem_address < 32'(DEPTH)) ? ram[mem_address[7:0]] : 32'h0;
    end

    always @(posedge clk) begin
        if (mem_we && mem_address < 32'(DEPTH)) ram[mem_address[7:0]] <= mem_data_in;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard: every response pulse pops the oldest expectation
    always @(negedge clk) begin
        if (mem_we) we_cnt++;
        if (rst_n && resp_valid) begin
            n_resp++;
            if (sb_q.size() == 0) begin
                check("unexpected_resp", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("resp_rdata", resp_rdata, e.rdata);
                check("resp_err", 32'(resp_err), 32'(e.err));
            end
        end
    end

    function automatic vec_t mk(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic [31:0] rdata,
                                input logic err, input int lat, input int wr);
        vec_t v;
        v.we = we; v.f3 = f3; v.addr = addr; v.wdata = wdata;
        v.rdata = rdata; v.err = err; v.lat = lat; v.wr = wr;
        return v;
    endfunction

    task automatic wait_ready(input string name);
        int t;
        t = 0;
        @(negedge clk);
        while (!req_ready && t < 20) begin
            @(negedge clk);
            t++;
        end
        check({name, "_ready"}, 32'(req_ready), 32'd1);
    endtask

    task automatic do_req(input vec_t v, input string name);
        int lat;
        int wr0;
        wait_ready(name);
        req_valid  = 1'b1;
        req_we     = v.we;
        req_funct3 = v.f3;
        req_addr   = v.addr;
        req_wdata  = v.wdata;
        sb_q.push_back('{v.rdata, v.err});
        n_sent++;
        wr0 = we_cnt;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_addr  = $urandom;
        req_wdata = $urandom;
        lat = 1;
        while (!resp_valid && lat < 10) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check({name, "_latency"}, 32'(lat), 32'(v.lat));
        check({name, "_writes"}, 32'(we_cnt - wr0), 32'(v.wr));
    endtask

    initial begin
        int wr0;
        int i;
        int cyc;
        int last_acc;

        for (int k = 0; k < int'(DEPTH); k++) ram[k] = 32'h0;
        rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0;
        req_funct3 = 3'b000; req_addr = 32'h0; req_wdata = 32'h0;

        #3;
        check("rst_ready", 32'(req_ready), 32'd1);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_rdata", resp_rdata, 32'h0);
        check("rst_err", 32'(resp_err), 32'd0);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        //             we    f3      addr       wdata         rdata         err lat wr
        vecs.push_back(mk(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 32'h00000000, 1'b0, 2, 1));
        vecs.push_back(mk(1'b0, 3'b010, 32'h10, 32'h0,        32'hDEADBEEF, 1'b0, 2, 0));
        vecs.push_back(mk(1'b1, 3'b000, 32'h13, 32'h0000007A, 32'h00000000, 1'b0, 3, 1));
        vecs.push_back(mk(1'b0, 3'b010, 32'h10, 32'h0,        32'h7AADBEEF, 1'b0, 2, 0));
        vecs.push_back(mk(1'b0, 3'b000, 32'h13, 32'h0,        32'h0000007A, 1'b0, 2, 0));
        vecs.push_back(mk(1'b0, 3'b100, 32'h12, 32'h0,        32'h000000AD, 1'b0, 2, 0));
        vecs.push_back(mk(1'b0, 3'b000, 32'h12, 32'h0,        32'hFFFFFFAD, 1'b0, 2, 0));
        vecs.push_back(mk(1'b1, 3'b001, 32'h12, 32'h00008001, 32'h00000000, 1'b0, 3, 1));
        vecs.push_back(mk(1'b0, 3'b010, 32'h10, 32'h0,        32'h8001BEEF, 1'b0, 2, 0));
        vecs.push_back(mk(1'b0, 3'b001, 32'h12, 32'h0,        32'hFFFF8001, 1'b0, 2, 0));
        vecs.push_back(mk(1'b0, 3'b101, 32'h12, 32'h0,        32'h00008001, 1'b0, 2, 0));
        vecs.push_back(mk(1'b0, 3'b001, 32'h10, 32'h0,        32'hFFFFBEEF, 1'b0, 2, 0));
        vecs.push_back(mk(1'b0, 3'b100, 32'h11, 32'h0,        32'h000000BE, 1'b0, 2, 0));
        vecs.push_back(mk(1'b0, 3'b010, 32'h11, 32'h0,        32'h00000000, 1'b1, 1, 0));
        vecs.push_back(mk(1'b1, 3'b001, 32'h13, 32'h0000FFFF, 32'h00000000, 1'b1, 1, 0));
        vecs.push_back(mk(1'b1, 3'b010, 32'h400, 32'h12345678, 32'h00000000, 1'b1, 1, 0));
        vecs.push_back(mk(1'b0, 3'b010, 32'h400, 32'h0,       32'h00000000, 1'b1, 1, 0));
        vecs.push_back(mk(1'b0, 3'b011, 32'h10, 32'h0,        32'h00000000, 1'b1, 1, 0));
        vecs.push_back(mk(1'b0, 3'b110, 32'h10, 32'h0,        32'h00000000, 1'b1, 1, 0));
        vecs.push_back(mk(1'b1, 3'b011, 32'h10, 32'h11111111, 32'h00000000, 1'b1, 1, 0));
        vecs.push_back(mk(1'b1, 3'b100, 32'h10, 32'h22222222, 32'h00000000, 1'b1, 1, 0));
        vecs.push_back(mk(1'b0, 3'b010, 32'h10, 32'h0,        32'h8001BEEF, 1'b0, 2, 0));
        vecs.push_back(mk(1'b1, 3'b000, 32'h3FC, 32'hAAAAAA55, 32'h00000000, 1'b0, 3, 1));
        vecs.push_back(mk(1'b0, 3'b010, 32'h3FC, 32'h0,       32'h00000055, 1'b0, 2, 0));
        vecs.push_back(mk(1'b0, 3'b000, 32'h3FD, 32'h0,       32'h00000000, 1'b0, 2, 0));
        vecs.push_back(mk(1'b1, 3'b001, 32'h20, 32'hFFFF1234, 32'h00000000, 1'b0, 3, 1));
        vecs.push_back(mk(1'b0, 3'b010, 32'h20, 32'h0,        32'h00001234, 1'b0, 2, 0));

        foreach (vecs[k]) do_req(vecs[k], $sformatf("vec%0d", k));
        check("word4_after_errors", ram[4], 32'h8001BEEF);

        // Reset asserted while a byte store sits in MERGE must abort without writing
        wait_ready("rst_abort");
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b000;
        req_addr = 32'h13; req_wdata = 32'h00000011;
        wr0 = we_cnt;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        check("abort_in_merge_ready", 32'(req_ready), 32'd0);
        #1 rst_n = 1'b0;
        #1;
        check("abort_mem_we", 32'(mem_we), 32'd0);
        check("abort_ready", 32'(req_ready), 32'd1);
        check("abort_resp_valid", 32'(resp_valid), 32'd0);
        check("abort_rdata", resp_rdata, 32'h0);
        check("abort_err", 32'(resp_err), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        check("abort_writes", 32'(we_cnt - wr0), 32'd0);
        check("abort_word4", ram[4], 32'h8001BEEF);
        do_req(mk(1'b0, 3'b010, 32'h10, 32'h0, 32'h8001BEEF, 1'b0, 2, 0), "post_abort_lw");

        // req_valid held high; fields scrambled whenever the unit is busy
        b2b.push_back(mk(1'b1, 3'b010, 32'h40, 32'hCAFEF00D, 32'h00000000, 1'b0, 2, 1));
        b2b.push_back(mk(1'b0, 3'b010, 32'h40, 32'h0,        32'hCAFEF00D, 1'b0, 2, 0));
        b2b.push_back(mk(1'b1, 3'b000, 32'h41, 32'h00000099, 32'h00000000, 1'b0, 3, 1));
        b2b.push_back(mk(1'b0, 3'b010, 32'h40, 32'h0,        32'hCAFE990D, 1'b0, 2, 0));
        wait_ready("b2b_start");
        i = 0; cyc = 0; last_acc = 0;
        req_valid = 1'b1;
        while (i < b2b.size() && cyc < 100) begin
            if (req_ready) begin
                req_we = b2b[i].we; req_funct3 = b2b[i].f3;
                req_addr = b2b[i].addr; req_wdata = b2b[i].wdata;
                sb_q.push_back('{b2b[i].rdata, b2b[i].err});
                n_sent++;
                if (i > 0) check($sformatf("b2b_interval%0d", i), 32'(cyc - last_acc),
                                 32'(b2b[i-1].lat + 1));
                last_acc = cyc;
                i++;
            end else begin
                req_we = 1'($urandom); req_funct3 = 3'($urandom);
                req_addr = $urandom; req_wdata = $urandom;
            end
            @(negedge clk);
            cyc++;
        end
        req_valid = 1'b0;
        check("b2b_all_accepted", 32'(i), 32'(b2b.size()));
        repeat (6) @(negedge clk);
        check("b2b_word16", ram[16], 32'hCAFE990D);

        check("resp_count", 32'(n_resp), 32'(n_sent));
        check("scoreboard_empty", 32'(sb_q.size()), 32'd0);
        check("word255", ram[255], 32'h00000055);
        check("word8", ram[8], 32'h00001234);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
